matrix_operand_feeder: RTL and testbench
========================================

# matrix_operand_feeder

Operand source that sits directly upstream of `matrix_mul`. It holds matrix A and matrix B in two on-chip register banks, which a host port loads. It answers `matrix_mul`'s `ren`/`raddr` read requests by streaming `sizes*sizes` signed 16-bit elements, one per clock, in row-major order. It replaces the behavioural data source used in simulation with synthesizable RTL.

## Interface
Parameters:
- `MAX_SIZE`, 6, largest supported matrix dimension; each bank holds MAX_SIZE*MAX_SIZE words.
- `DW`, 16, element width; elements are signed two's complement.

Ports:
- `clk` input 1: clock, rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `sizes` input 4: matrix dimension n. Valid range is 1..MAX_SIZE. Sampled at burst start.
- `host_we` input 1: host write strobe.
- `host_sel` input 1: bank select, 0 = A, 1 = B.
- `host_addr` input 6: packed element index r*n+c.
- `host_wdata` input DW: element value, signed.
- `ren` input 1: read request from `matrix_mul`.
- `raddr` input 1: requested bank, 0 = A, 1 = B.
- `rdata` output DW: streamed element, signed, registered.
- `rvalid` output 1: `rdata` holds a burst element.
- `burst_done` output 1: one-cycle pulse after the last element of a burst.
- `elem_cnt` output 9: number of elements issued in the current burst.
- `err` output 1: one-cycle pulse on a rejected operation.

## Operation
- States: IDLE, STREAM, DONE, HOLD.
- **IDLE → STREAM:** taken when `ren`=1 at a clock edge with n valid.
  - The bank is latched from `raddr` and n is latched from `sizes`.
  - On the same edge: `rdata` <= bank[0], `rvalid` <= 1, `elem_cnt` <= 1.
- **STREAM:** on each edge with `ren`=1:
  - Index i increments.
  - `rdata` <= bank[i], `elem_cnt` <= i+1.
  - After element n*n-1 is issued, the next edge goes to DONE.
- **DONE:** lasts one cycle.
  - `burst_done`=1, `rvalid`=0, `rdata` <= 0.
  - Then HOLD if `ren`=1, otherwise IDLE.
- **HOLD:** waits for a new request.
  - If `ren` falls, go to IDLE.
  - If `ren` stays high and `raddr` differs from the last burst's bank, start a new burst exactly as from IDLE. This supports an A-then-B sequence with `ren` held high.
  - If `raddr` matches the last burst's bank, stay in HOLD with no second burst.
- **Abort:** `ren`=0 during STREAM goes to IDLE on that edge.
  - `rvalid` <= 0, `rdata` <= 0, `elem_cnt` is held.
  - No `burst_done` pulse.
- **Invalid size:** `sizes`=0 or `sizes`>MAX_SIZE at a request edge.
  - `err` pulses and the state stays IDLE/HOLD.
  - The request is retried on every edge while `ren`=1 and pulses `err` each time.
- **Host writes:** accepted in any state when `host_addr` < MAX_SIZE*MAX_SIZE. The bank is updated on the edge.
  - A write to the bank currently being streamed is dropped and `err` pulses.
  - A write to the other bank is accepted.
  - An out-of-range `host_addr` is dropped and `err` pulses.
- **Simultaneous errors:** multiple errors in one cycle produce a single `err` pulse.
- **Reset values:** on `rstn`=0 at an edge (including mid-burst):
  - State goes to IDLE.
  - `rdata`=0, `rvalid`=0, `burst_done`=0, `elem_cnt`=0, `err`=0.
  - Bank contents are not cleared.

## Timing
- Latency from the request edge to the first valid `rdata` is one cycle; `rdata` is registered on the request edge.
- Throughput is one element per cycle with no bubbles.
- A burst occupies n*n cycles of `rvalid`, followed by one `burst_done` cycle.
- A back-to-back A→B sequence with `ren` held high: the B burst starts on the edge after DONE. The gap is exactly one `rvalid`=0 cycle.
- A host write on edge k is visible to a burst read on edge k+1 or later.

## Configuration
- `FEEDER_TRANSPOSE_B_EN`
  - Defined: bank B streams in column-major order, issuing B[c*n+r] for r outer, c inner, i.e. B transposed. This lets the consumer walk B columns sequentially. Bank A is unaffected.
  - Undefined: both banks stream row-major and the transpose address logic is not present.

## Test plan
- n=3, load A=1..9, `ren`=1 with `raddr`=0 for 9 cycles → `rdata` = 1,2,...,9 with `rvalid`=1 for 9 consecutive cycles, then `burst_done` pulses and `elem_cnt`=9.
- n=2, A={1,2,3,4}, B={-5,6,-7,8}, `ren` held high with `raddr` 0 then 1 → stream 1,2,3,4, one idle cycle, then -5,6,-7,8. With `FEEDER_TRANSPOSE_B_EN` defined the B stream is -5,-7,6,8.
- n=6, 36-element burst, `ren` dropped after element 10 → `rvalid`=0 on the next edge, no `burst_done`, `elem_cnt` holds 10.
- `sizes`=7 or `sizes`=0 with `ren`=1 → `err` pulses every cycle and `rvalid` stays 0.
- During a burst from A: a host write to A addr 2 → `err` pulses and the A element is unchanged on the next burst. A host write to B addr 2 with value 0x7FFF → B[2]=32767 on the next B burst. `host_addr`=40 → `err` pulses.
- Assert `rstn`=0 mid-burst at element 4 of 9 → all outputs return to 0 on the next edge. A fresh request afterwards restarts at element 0 with the bank contents retained.

Source files
------------

// File: rtl/matrix_operand_feeder.sv
// matrix_operand_feeder: two host-loaded operand banks (A, B) streamed to
// matrix_mul one signed element per clock in response to ren/raddr.
// Optional build macro FEEDER_TRANSPOSE_B_EN makes bank B stream transposed
// (column-major); when undefined both banks stream row-major.
module matrix_operand_feeder #(
  parameter int MAX_SIZE = 6,
  parameter int DW       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3:0]           sizes,
  input  logic                 host_we,
  input  logic                 host_sel,
  input  logic [5:0]           host_addr,
  input  logic signed [DW-1:0] host_wdata,
  input  logic                 ren,
  input  logic                 raddr,
  output logic signed [DW-1:0] rdata,
  output logic                 rvalid,
  output logic                 burst_done,
  output logic [8:0]           elem_cnt,
  output logic                 err
);

  localparam int unsigned DEPTH = MAX_SIZE * MAX_SIZE;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0] state;
  logic       bank_sel;
  logic [3:0] n_lat;
  logic [5:0] idx;

  logic signed [DW-1:0] bank_a [DEPTH];
  logic signed [DW-1:0] bank_b [DEPTH];

  logic       size_ok, start_req, start, size_err;
  logic       wr_in_range, wr_conflict, wr_ok, wr_err;
  logic [7:0] nn;
  logic       last;
  logic [5:0] idx_nx, stream_addr, rd_addr;
  logic       rd_sel;
  logic signed [DW-1:0] rd_word;

`ifdef FEEDER_TRANSPOSE_B_EN
  logic [3:0] row, col, row_nx, col_nx;
`endif

  // Request decode, host-write checks and next-element read address
  always_comb begin
    size_ok     = (sizes != 4'd0) && (int'(sizes) <= MAX_SIZE);
    // DONE evaluates a new request directly so an A->B switch costs one gap cycle
    start_req   = ren && ((state == IDLE) ||
                          (((state == HOLD) || (state == DONE)) && (raddr != bank_sel)));
    start       = start_req && size_ok;
    size_err    = start_req && !size_ok;

    wr_in_range = 32'(host_addr) < DEPTH;
    wr_conflict = host_we && wr_in_range && (state == STREAM) && (host_sel == bank_sel);
    wr_ok       = host_we && wr_in_range && !wr_conflict;
    wr_err      = host_we && (!wr_in_range || wr_conflict);

    nn     = {4'b0, n_lat} * {4'b0, n_lat};
    last   = ({2'b0, idx} == (nn - 8'd1));
    idx_nx = idx + 6'd1;

`ifdef FEEDER_TRANSPOSE_B_EN
    if (col == n_lat - 4'd1) begin
      col_nx = 4'd0;
      row_nx = row + 4'd1;
    end else begin
      col_nx = col + 4'd1;
      row_nx = row;
    end
    stream_addr = bank_sel ? ({2'b0, col_nx} * {2'b0, n_lat} + {2'b0, row_nx}) : idx_nx;
`else
    stream_addr = idx_nx;
`endif

    rd_sel  = start ? raddr : bank_sel;
    rd_addr = start ? 6'd0 : stream_addr;
    rd_word = rd_sel ? bank_b[rd_addr] : bank_a[rd_addr];
  end

  // Burst sequencing and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      bank_sel   <= 1'b0;
      n_lat      <= '0;
      idx        <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      burst_done <= 1'b0;
      elem_cnt   <= '0;
      err        <= 1'b0;
`ifdef FEEDER_TRANSPOSE_B_EN
      row        <= '0;
      col        <= '0;
`endif
    end else begin
      err        <= size_err | wr_err;
      burst_done <= 1'b0;
      if (state == STREAM) begin
        // A fully issued burst completes even if ren drops on the final edge
        if (last) begin
          state      <= DONE;
          burst_done <= 1'b1;
          rvalid     <= 1'b0;
          rdata      <= '0;
        end else if (!ren) begin
          state  <= IDLE;
          rvalid <= 1'b0;
          rdata  <= '0;
        end else begin
          idx      <= idx_nx;
          rdata    <= rd_word;
          elem_cnt <= {3'b0, idx} + 9'd2;
`ifdef FEEDER_TRANSPOSE_B_EN
          row      <= row_nx;
          col      <= col_nx;
`endif
        end
      end else if (start) begin
        state    <= STREAM;
        bank_sel <= raddr;
        n_lat    <= sizes;
        idx      <= '0;
        rdata    <= rd_word;
        rvalid   <= 1'b1;
        elem_cnt <= 9'd1;
`ifdef FEEDER_TRANSPOSE_B_EN
        row      <= '0;
        col      <= '0;
`endif
      end else begin
        rvalid <= 1'b0;
        rdata  <= '0;
        state  <= ((state == IDLE) || !ren) ? IDLE : HOLD;
      end
    end
  end

  // Host writes into the operand banks (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (host_sel) bank_b[host_addr] <= host_wdata;
      else          bank_a[host_addr] <= host_wdata;
    end
  end

endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Directed bench for matrix_operand_feeder: bank model plus expected-element
// queue, streamed elements checked as they appear on rdata/rvalid.
module tb_matrix_operand_feeder;

  logic              clk;
  logic              rstn;
  logic [3:0]        sizes;
  logic              host_we;
  logic              host_sel;
  logic [5:0]        host_addr;
  logic signed [15:0] host_wdata;
  logic              ren;
  logic              raddr;
  logic signed [15:0] rdata;
  logic              rvalid;
  logic              burst_done;
  logic [8:0]        elem_cnt;
  logic              err;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] ma [36];
  logic signed [15:0] mb [36];
  logic signed [15:0] sb [$];
  logic signed [15:0] exp_v;

  matrix_operand_feeder #(.MAX_SIZE(6), .DW(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sizes      (sizes),
    .host_we    (host_we),
    .host_sel   (host_sel),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .burst_done (burst_done),
    .elem_cnt   (elem_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [5:0] addr, input logic signed [15:0] data,
                    input logic accept);
    host_we    = 1'b1;
    host_sel   = sel;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_we = 1'b0;
    if (accept) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  // Queue the first cnt elements a burst of size n from bank sel should produce
  task automatic push_burst(input logic sel, input int n, input int cnt);
    int k;
    k = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        if (k < cnt) begin
          if (!sel) sb.push_back(ma[r*n+c]);
`ifdef FEEDER_TRANSPOSE_B_EN
          else      sb.push_back(mb[c*n+r]);
`else
          else      sb.push_back(mb[r*n+c]);
`endif
        end
        k++;
      end
  endtask

  // Streamed elements are compared against the queue in issue order
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL stream_extra observed=%0d expected=none", rdata);
      end else begin
        exp_v = sb.pop_front();
        assert (rdata === exp_v) else begin
          errors++;
          $error("FAIL stream_data observed=%0d expected=%0d", rdata, exp_v);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; sizes = 4'd3; host_we = 1'b0; host_sel = 1'b0;
    host_addr = '0; host_wdata = '0; ren = 1'b0; raddr = 1'b0;
    tick(); tick();
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_done", 32'(burst_done), 32'(0));
    chk("rst_cnt", 32'(elem_cnt), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rstn = 1'b1;

    // Preload both banks: A = 1..36, B = 100..135
    for (int i = 0; i < 36; i++) wr(1'b0, 6'(i), 16'(i + 1), 1'b1);
    for (int i = 0; i < 36; i++) wr(1'b1, 6'(i), 16'(i + 100), 1'b1);
    chk("load_err", 32'(err), 32'(0));

    // n=3 burst from A
    sizes = 4'd3;
    push_burst(1'b0, 3, 9);
    ren = 1'b1; raddr = 1'b0;
    tick();
    chk("b3_first_valid", 32'(rvalid), 32'(1));
    chk("b3_first_cnt", 32'(elem_cnt), 32'(1));
    repeat (8) tick();
    chk("b3_last_cnt", 32'(elem_cnt), 32'(9));
    ren = 1'b0;
    tick();
    chk("b3_done", 32'(burst_done), 32'(1));
    chk("b3_done_valid", 32'(rvalid), 32'(0));
    chk("b3_done_cnt", 32'(elem_cnt), 32'(9));
    chk("b3_done_rdata", 32'(rdata), 32'(0));
    tick();
    chk("b3_done_pulse", 32'(burst_done), 32'(0));

    // n=2 A then B with ren held high
    wr(1'b0, 6'd0, 16'sd1, 1'b1);  wr(1'b0, 6'd1, 16'sd2, 1'b1);
    wr(1'b0, 6'd2, 16'sd3, 1'b1);  wr(1'b0, 6'd3, 16'sd4, 1'b1);
    wr(1'b1, 6'd0, -16'sd5, 1'b1); wr(1'b1, 6'd1, 16'sd6, 1'b1);
    wr(1'b1, 6'd2, -16'sd7, 1'b1); wr(1'b1, 6'd3, 16'sd8, 1'b1);
    sizes = 4'd2;
    push_burst(1'b0, 2, 4);
    push_burst(1'b1, 2, 4);
    ren = 1'b1; raddr = 1'b0;
    tick();
    raddr = 1'b1;
    repeat (3) tick();
    tick();
    chk("ab_gap_done", 32'(burst_done), 32'(1));
    chk("ab_gap_valid", 32'(rvalid), 32'(0));
    tick();
    chk("ab_b_start_valid", 32'(rvalid), 32'(1));
    chk("ab_b_start_cnt", 32'(elem_cnt), 32'(1));
    repeat (3) tick();
    tick();
    chk("ab_b_done", 32'(burst_done), 32'(1));
    tick();
    chk("hold_no_burst", 32'(rvalid), 32'(0));
    tick();
    chk("hold_still_idle", 32'(rvalid), 32'(0));
    chk("hold_no_done", 32'(burst_done), 32'(0));
    ren = 1'b0;
    tick();

    // n=6 burst aborted after element 10
    sizes = 4'd6;
    push_burst(1'b0, 6, 10);
    ren = 1'b1; raddr = 1'b0;
    repeat (10) tick();
    chk("abort_cnt_pre", 32'(elem_cnt), 32'(10));
    ren = 1'b0;
    tick();
    chk("abort_valid", 32'(rvalid), 32'(0));
    chk("abort_cnt_hold", 32'(elem_cnt), 32'(10));
    chk("abort_no_done", 32'(burst_done), 32'(0));
    tick();
    chk("abort_no_done2", 32'(burst_done), 32'(0));

    // Invalid sizes retry and pulse err every cycle
    sizes = 4'd7; ren = 1'b1;
    tick();
    chk("size7_err", 32'(err), 32'(1));
    chk("size7_valid", 32'(rvalid), 32'(0));
    tick();
    chk("size7_err_again", 32'(err), 32'(1));
    sizes = 4'd0;
    tick();
    chk("size0_err", 32'(err), 32'(1));
    chk("size0_valid", 32'(rvalid), 32'(0));
    ren = 1'b0;
    tick();
    chk("size_err_clear", 32'(err), 32'(0));

    // Host writes during an A burst
    sizes = 4'd3;
    push_burst(1'b0, 3, 9);
    ren = 1'b1; raddr = 1'b0;
    tick();
    wr(1'b0, 6'd2, 16'sd999, 1'b0);
    chk("wr_conflict_err", 32'(err), 32'(1));
    wr(1'b1, 6'd2, 16'sh7FFF, 1'b1);
    chk("wr_other_ok", 32'(err), 32'(0));
    wr(1'b1, 6'd40, 16'sd55, 1'b0);
    chk("wr_range_err", 32'(err), 32'(1));
    repeat (5) tick();
    ren = 1'b0;
    tick();
    chk("wr_burst_done", 32'(burst_done), 32'(1));
    tick();
    push_burst(1'b0, 3, 9);
    ren = 1'b1; raddr = 1'b0;
    repeat (9) tick();
    ren = 1'b0;
    tick(); tick();
    push_burst(1'b1, 3, 9);
    ren = 1'b1; raddr = 1'b1;
    repeat (9) tick();
    ren = 1'b0;
    tick(); tick();

    // Reset mid-burst at element 4, then a fresh burst
    push_burst(1'b0, 3, 4);
    ren = 1'b1; raddr = 1'b0;
    repeat (4) tick();
    chk("mid_cnt", 32'(elem_cnt), 32'(4));
    rstn = 1'b0; ren = 1'b0;
    tick();
    chk("mid_rst_rdata", 32'(rdata), 32'(0));
    chk("mid_rst_valid", 32'(rvalid), 32'(0));
    chk("mid_rst_cnt", 32'(elem_cnt), 32'(0));
    chk("mid_rst_done", 32'(burst_done), 32'(0));
    chk("mid_rst_err", 32'(err), 32'(0));
    rstn = 1'b1;
    push_burst(1'b0, 3, 9);
    ren = 1'b1;
    tick();
    chk("restart_cnt", 32'(elem_cnt), 32'(1));
    repeat (8) tick();
    ren = 1'b0;
    tick();
    chk("restart_done", 32'(burst_done), 32'(1));
    tick();

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
